sram_access_sequencer: RTL and testbench

Multi-cycle controller between the MEM stage and the off-chip 16-bit SRAM. It takes the 32-bit word request that the EXE stage produces (the ALU result as address, plus the forwarded Rm value as store data) and splits it into two 16-bit SRAM half-word accesses. It then waits a fixed settle period and returns the assembled read word.
While an access is in flight it deasserts ready, and the pipeline freezes on that signal.

---
 rtl/sram_access_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sram_access_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// sram_access_sequencer
//
// Multi-cycle bridge between the MEM stage and an off-chip 16-bit SRAM.
// Each 32-bit request is split into two half-word accesses (low half, then
// high half). A programmable settle period follows the second access. For
// loads, the two captured halves are then assembled into readData. While an
// access is outstanding, ready is held low so that the pipeline freezes.
//
// Parameters:
//   WAIT_CYCLES : idle cycles after the high half-word access (0..15)
//   DATA_BASE   : byte address that maps to SRAM half-word 0
//
// Ports:
//   clk        : system clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   rd_en      : load request from the MEM stage
//   wr_en      : store request from the MEM stage (wins over rd_en)
//   address    : byte address (ALU result)
//   writeData  : store data (forwarded Rm value)
//   readData   : assembled load data, registered, holds until next load
//   ready      : low while a request is outstanding and not complete
//   SRAM_DQ    : bidirectional SRAM data bus
//   SRAM_ADDR  : SRAM half-word address
//   SRAM_WE_N  : write enable, active low
//   SRAM_OE_N  : output enable, active low
//   SRAM_CE_N  : chip enable, tied active
//   SRAM_UB_N  : upper byte enable, tied active
//   SRAM_LB_N  : lower byte enable, tied active
// -----------------------------------------------------------------------------
module sram_access_sequencer #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] DATA_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC_LO,
        S_ACC_HI,
        S_WAIT,
        S_DONE
    } state_t;

    // Value loaded into the settle counter on leaving ACC_HI. The WAIT state
    // is skipped entirely when WAIT_CYCLES is zero, so the load value is
    // irrelevant in that case.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic        op_write;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] lo_q;
    logic [15:0] hi_q;

    logic [16:0] word;
    logic        dq_drive;
    logic [15:0] dq_out;

    // Word index inside the SRAM. The subtraction wraps modulo 2^32. Byte
    // offset bits [1:0] are dropped, so every access is word aligned.
    assign word = 17'((addr_q - DATA_BASE) >> 2);

    // Control strobes are fixed: the part is always selected with both bytes
    // enabled. WE_N and OE_N alone qualify each access.
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign SRAM_DQ = dq_drive ? dq_out : 16'bz;

    // ready is combinational on the request lines. This lets an idle pipeline
    // run freely. A stalled pipeline advances exactly on the edge that ends DONE.
    assign ready = ~(rd_en | wr_en) | (state == S_DONE);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // that no path leaves it unassigned (which would infer a latch).
        state_next = state;
        unique case (state)
            S_IDLE:   if (wr_en || rd_en) state_next = S_ACC_LO;
            S_ACC_LO: state_next = S_ACC_HI;
            S_ACC_HI: state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
            S_WAIT:   if (wait_cnt == 4'd0) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore SRAM pin decode from state and latched operation
    // -------------------------------------------------------------------------
    always_comb begin
        SRAM_ADDR = 18'd0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_drive  = 1'b0;
        dq_out    = 16'd0;
        unique case (state)
            S_ACC_LO: begin
                SRAM_ADDR = {word, 1'b0};
                if (op_write) begin
                    SRAM_WE_N = 1'b0;
                    dq_drive  = 1'b1;
                    dq_out    = wdata_q[15:0];
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            S_ACC_HI: begin
                SRAM_ADDR = {word, 1'b1};
                if (op_write) begin
                    SRAM_WE_N = 1'b0;
                    dq_drive  = 1'b1;
                    dq_out    = wdata_q[31:16];
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counter and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers therefore update together from pre-edge values, whatever
    // order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            readData <= 32'd0;
            op_write <= 1'b0;
            // NOTE: the request and capture latches are also cleared. Every
            // register then has a defined value after reset, and a reset
            // in the middle of an access cannot leak stale data.
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            lo_q     <= 16'd0;
            hi_q     <= 16'd0;
        end else begin
            state <= state_next;

            unique case (state)
                S_IDLE: begin
                    // wr_en takes priority when both requests are present.
                    if (wr_en) begin
                        op_write <= 1'b1;
                        addr_q   <= address;
                        wdata_q  <= writeData;
                    end else if (rd_en) begin
                        op_write <= 1'b0;
                        addr_q   <= address;
                    end
                end
                S_ACC_LO: begin
                    if (!op_write) lo_q <= SRAM_DQ;
                end
                S_ACC_HI: begin
                    if (!op_write) hi_q <= SRAM_DQ;
                    wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                end
                S_DONE: begin
                    if (!op_write) readData <= {hi_q, lo_q};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_access_sequencer
//
// Bench for sram_access_sequencer. There are two instances: the default
// configuration (WAIT_CYCLES=2) and a zero-wait configuration. Each instance
// drives a simple behavioural SRAM. The expected results come from a
// word-level reference model. This model is an associative array of
// half-words, addressed by arithmetic on the byte address. Per-cycle
// expectations follow the documented access timeline.
// -----------------------------------------------------------------------------
module tb_sram_access_sequencer;

    localparam int W_A = 2;   // settle cycles of instance A

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A (default parameters)
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    // Instance B (WAIT_CYCLES = 0)
    logic        rd_en_b, wr_en_b;
    logic [31:0] address_b, write_data_b, read_data_b;
    logic        ready_b;
    wire  [15:0] sram_dq_b;
    logic [17:0] sram_addr_b;
    logic        we_n_b, oe_n_b, ce_n_b, ub_n_b, lb_n_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] last_rd;

    sram_access_sequencer dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .writeData(write_data), .readData(read_data),
        .ready(ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    sram_access_sequencer #(.WAIT_CYCLES(0), .DATA_BASE(32'd1024)) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en_b), .wr_en(wr_en_b),
        .address(address_b), .writeData(write_data_b), .readData(read_data_b),
        .ready(ready_b), .SRAM_DQ(sram_dq_b), .SRAM_ADDR(sram_addr_b),
        .SRAM_WE_N(we_n_b), .SRAM_OE_N(oe_n_b), .SRAM_CE_N(ce_n_b),
        .SRAM_UB_N(ub_n_b), .SRAM_LB_N(lb_n_b)
    );

    // Behavioural SRAMs: drive the bus on OE with WE high, write on WE low.
    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];

    assign sram_dq   = (!oe_n   && we_n)   ? mem_a[sram_addr]   : 16'bz;
    assign sram_dq_b = (!oe_n_b && we_n_b) ? mem_b[sram_addr_b] : 16'bz;

    always @(posedge clk) begin
        if (!we_n)   mem_a[sram_addr]   <= sram_dq;
        if (!we_n_b) mem_b[sram_addr_b] <= sram_dq_b;
    end

    // Reference model: half-word contents keyed by SRAM half-word index.
    logic [15:0] ref_mem [int unsigned];

    function automatic int unsigned hw_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return ((off >> 2) & 32'h1FFFF) * 2;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int unsigned i;
        logic [15:0] lo;
        logic [15:0] hi;
        i  = hw_index(a);
        lo = ref_mem.exists(i)     ? ref_mem[i]     : 16'h0000;
        hi = ref_mem.exists(i + 1) ? ref_mem[i + 1] : 16'h0000;
        return {hi, lo};
    endfunction

    // One complete access on instance A, checked cycle by cycle. Call it at
    // the start of a cycle with the DUT idle. Cycle 0 is the IDLE cycle that
    // samples the request; the request is removed at the start of cycle
    // drop_at (use a large value for "never dropped").
    task automatic access_a(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d, input int drop_at, input string tag);
        logic        is_wr;
        int unsigned hw;
        logic [31:0] exp_rd;
        logic        req;
        logic        exp_ready, exp_we, exp_oe;
        logic [17:0] exp_addr;
        int          last_cycle;
        is_wr      = w;
        hw         = hw_index(a);
        exp_rd     = ref_read(a);
        last_cycle = 3 + W_A;
        wr_en = w; rd_en = r; address = a; write_data = d;
        for (int c = 0; c <= last_cycle; c++) begin
            if (c == drop_at) begin
                wr_en = 1'b0;
                rd_en = 1'b0;
            end
            @(negedge clk);
            req       = (c < drop_at) ? (w | r) : 1'b0;
            exp_ready = !req || (c == last_cycle);
            exp_we    = !(is_wr && (c == 1 || c == 2));
            exp_oe    = !(!is_wr && (c == 1 || c == 2));
            exp_addr  = (c == 1) ? 18'(hw) : (c == 2) ? 18'(hw + 1) : 18'd0;
            n_cmp++;
            if (ready !== exp_ready) begin
                n_err++;
                $display("FAIL %s c%0d ready: got %b want %b", tag, c, ready, exp_ready);
            end
            n_cmp++;
            if (we_n !== exp_we || oe_n !== exp_oe) begin
                n_err++;
                $display("FAIL %s c%0d we_n/oe_n: got %b%b want %b%b", tag, c, we_n, oe_n, exp_we, exp_oe);
            end
            n_cmp++;
            if (sram_addr !== exp_addr) begin
                n_err++;
                $display("FAIL %s c%0d sram_addr: got %h want %h", tag, c, sram_addr, exp_addr);
            end
            if (is_wr && (c == 1 || c == 2)) begin
                n_cmp++;
                if (sram_dq !== ((c == 1) ? d[15:0] : d[31:16])) begin
                    n_err++;
                    $display("FAIL %s c%0d dq: got %h want %h", tag, c, sram_dq,
                             (c == 1) ? d[15:0] : d[31:16]);
                end
            end
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (is_wr) begin
            ref_mem[hw]     = d[15:0];
            ref_mem[hw + 1] = d[31:16];
        end else begin
            last_rd = exp_rd;
        end
        // Cycle after DONE: back in IDLE with no request.
        @(negedge clk);
        n_cmp++;
        if (read_data !== last_rd) begin
            n_err++;
            $display("FAIL %s readData: got %h want %h", tag, read_data, last_rd);
        end
        n_cmp++;
        if (ready !== 1'b1 || we_n !== 1'b1 || oe_n !== 1'b1) begin
            n_err++;
            $display("FAIL %s idle after done: ready %b we_n %b oe_n %b want 1 1 1", tag, ready, we_n, oe_n);
        end
        if (is_wr) begin
            n_cmp++;
            if ({mem_a[hw + 1], mem_a[hw]} !== d) begin
                n_err++;
                $display("FAIL %s sram contents: got %h want %h", tag, {mem_a[hw + 1], mem_a[hw]}, d);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        rd_en_b = 1'b0; wr_en_b = 1'b0; address_b = 32'd0; write_data_b = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        n_cmp++;
        if (read_data !== 32'd0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset readData/ready: got %h %b want 0 1", read_data, ready);
        end
        n_cmp++;
        if (sram_addr !== 18'd0 || we_n !== 1'b1 || oe_n !== 1'b1) begin
            n_err++;
            $display("FAIL reset sram idle: addr %h we_n %b oe_n %b want 0 1 1", sram_addr, we_n, oe_n);
        end
        n_cmp++;
        if (ce_n !== 1'b0 || ub_n !== 1'b0 || lb_n !== 1'b0) begin
            n_err++;
            $display("FAIL reset strobes: ce %b ub %b lb %b want 0 0 0", ce_n, ub_n, lb_n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        access_a(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 99, "store");
        n_cmp++;
        if (mem_a[0] !== 16'hBEEF || mem_a[1] !== 16'hDEAD) begin
            n_err++;
            $display("FAIL store halves: got %h %h want beef dead", mem_a[0], mem_a[1]);
        end
    endtask

    task automatic test_load();
        // Unrelated writeData on the port must not reach the bus.
        access_a(1'b0, 1'b1, 32'd1024, 32'h5A5A5A5A, 99, "load");
    endtask

    task automatic test_alignment();
        access_a(1'b1, 1'b0, 32'd1031, 32'h12345678, 99, "align_st");
        n_cmp++;
        if (mem_a[2] !== 16'h5678 || mem_a[3] !== 16'h1234) begin
            n_err++;
            $display("FAIL align halves: got %h %h want 5678 1234", mem_a[2], mem_a[3]);
        end
        access_a(1'b0, 1'b1, 32'd1028, 32'h0, 99, "align_ld");
        // Below DATA_BASE wraps to the top word of the SRAM.
        access_a(1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 99, "wrap_st");
        access_a(1'b0, 1'b1, 32'd1023, 32'h0, 99, "wrap_ld");
    endtask

    task automatic test_priority();
        access_a(1'b1, 1'b1, 32'd1100, 32'hA1B2C3D4, 99, "prio");
        access_a(1'b0, 1'b1, 32'd1100, 32'h0, 99, "prio_ld");
    endtask

    task automatic test_drop();
        access_a(1'b1, 1'b0, 32'd1200, 32'h0BADF00D, 2, "drop");
        access_a(1'b0, 1'b1, 32'd1200, 32'h0, 99, "drop_ld");
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd2048; write_data = 32'h77778888;
        @(posedge clk); #1;            // now ACC_LO
        @(posedge clk); #1;            // now ACC_HI
        @(negedge clk);
        n_cmp++;
        if (we_n !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid pre: we_n got %b want 0", we_n);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_en = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        n_cmp++;
        if (we_n !== 1'b1 || oe_n !== 1'b1 || sram_addr !== 18'd0) begin
            n_err++;
            $display("FAIL rstmid idle: we_n %b oe_n %b addr %h want 1 1 0", we_n, oe_n, sram_addr);
        end
        n_cmp++;
        if (read_data !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid readData: got %h want 0", read_data);
        end
        @(posedge clk); #1;
        access_a(1'b0, 1'b1, 32'd1024, 32'h0, 99, "rstmid_ld");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        w;
        for (int i = 0; i < 24; i++) begin
            a = 32'd1024 + 32'($urandom_range(0, 63));
            w = 1'($urandom_range(0, 1));
            if (!ref_mem.exists(hw_index(a))) w = 1'b1;
            access_a(w, !w, a, $urandom, 99, "rand");
        end
    endtask

    // Zero-wait instance. The requester advances only when it sees ready,
    // so the store is followed by a load with no gap.
    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        int unsigned hw;
        a  = 32'd1040;
        d  = $urandom;
        hw = hw_index(a);
        wr_en_b = 1'b1; address_b = a; write_data_b = d;
        for (int op = 0; op < 2; op++) begin
            for (int c = 0; c <= 3; c++) begin
                @(negedge clk);
                n_cmp++;
                if (ready_b !== (c == 3)) begin
                    n_err++;
                    $display("FAIL b2b op%0d c%0d ready: got %b want %b", op, c, ready_b, (c == 3));
                end
                n_cmp++;
                if (we_n_b !== !(op == 0 && (c == 1 || c == 2)) ||
                    oe_n_b !== !(op == 1 && (c == 1 || c == 2))) begin
                    n_err++;
                    $display("FAIL b2b op%0d c%0d we_n/oe_n: got %b%b", op, c, we_n_b, oe_n_b);
                end
                if (c == 1) begin
                    n_cmp++;
                    if (sram_addr_b !== 18'(hw)) begin
                        n_err++;
                        $display("FAIL b2b op%0d addr: got %h want %h", op, sram_addr_b, 18'(hw));
                    end
                end
                @(posedge clk); #1;
            end
            // Edge ending DONE: requester advances to the next request.
            wr_en_b = 1'b0;
            rd_en_b = (op == 0);
            write_data_b = ~d;
        end
        @(negedge clk);
        n_cmp++;
        if (read_data_b !== d) begin
            n_err++;
            $display("FAIL b2b readData: got %h want %h", read_data_b, d);
        end
        n_cmp++;
        if ({mem_b[hw + 1], mem_b[hw]} !== d) begin
            n_err++;
            $display("FAIL b2b sram contents: got %h want %h", {mem_b[hw + 1], mem_b[hw]}, d);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_alignment();
        test_priority();
        test_drop();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
